// File: rtl/ddr_rw_arbiter_if.sv
// ddr_rw_arbiter_if: user write/read burst ports and DDR app-side command/data signals
interface ddr_rw_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 10
);
  logic              init_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_length;
  logic              wr_ack;
  logic [DATA_W-1:0] wr_data;
  logic              wr_finish;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_length;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_finish;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic [DATA_W-1:0] app_rd_data;
  modport master (
    input  init_done, wr_req, wr_addr, wr_length, wr_data, rd_req, rd_addr, rd_length,
           app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    output wr_ack, wr_finish, rd_ack, rd_data, rd_finish,
           app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data
  );
  modport slave (
    output init_done, wr_req, wr_addr, wr_length, wr_data, rd_req, rd_addr, rd_length,
           app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    input  wr_ack, wr_finish, rd_ack, rd_data, rd_finish,
           app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data
  );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: round-robin write/read burst arbiter in front of a DDR app interface
module ddr_rw_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 10,
  parameter int ADDR_STEP = 1
) (
  input logic clk_ref,
  input logic rst,
  ddr_rw_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t            state, state_nx;
  logic              last_rd, is_rd, grant, pick_rd, busy;
  logic [ADDR_W-1:0] base;
  logic [LEN_W:0]    len, cmd_cnt, dat_cnt, cmd_nx, dat_nx;

  always_comb begin
    busy             = state == WRITE || state == READ;
    bus.app_en       = busy && cmd_cnt < len;
    bus.app_cmd      = {2'b00, state == READ};
    bus.app_addr     = base + ADDR_W'(cmd_cnt) * ADDR_W'(ADDR_STEP);
    bus.app_wdf_wren = state == WRITE && dat_cnt < len;
    bus.app_wdf_data = bus.wr_data;
    bus.wr_ack       = bus.app_wdf_wren && bus.app_wdf_rdy;
    bus.rd_ack       = state == READ && bus.app_rd_data_valid;
    bus.rd_data      = bus.app_rd_data;
    bus.wr_finish    = state == DONE && !is_rd;
    bus.rd_finish    = state == DONE && is_rd;
    cmd_nx           = cmd_cnt + (LEN_W+1)'(bus.app_en && bus.app_rdy);
    dat_nx           = dat_cnt + (LEN_W+1)'(bus.wr_ack || bus.rd_ack);
    grant            = state == IDLE && bus.init_done && (bus.wr_req || bus.rd_req);
    // last_rd set means the write side wins the next tie
    pick_rd          = bus.rd_req && (!bus.wr_req || !last_rd);
    state_nx         = grant ? (pick_rd ? READ : WRITE) :
                       (busy && cmd_nx == len && dat_nx == len) ? DONE :
                       state == DONE ? IDLE : state;
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_rd <= 1'b1;
      is_rd   <= 1'b0;
      base    <= '0;
      len     <= '0;
      cmd_cnt <= '0;
      dat_cnt <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        is_rd   <= pick_rd;
        last_rd <= pick_rd;
        base    <= pick_rd ? bus.rd_addr : bus.wr_addr;
        len     <= {1'b0, pick_rd ? bus.rd_length : bus.wr_length};
        cmd_cnt <= '0;
        dat_cnt <= '0;
      end else if (busy) begin
        cmd_cnt <= cmd_nx;
        dat_cnt <= dat_nx;
      end
    end
  end
endmodule

// File: doc/ddr_rw_arbiter.md
DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 25, DDR beat address width; DATA_W, 256, beat data width; LEN_W, 10, burst length width; ADDR_STEP, 1, address increment per beat.
REQ-002 clk_ref  in  1  single clock for all logic.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 init_done  in  1  DDR calibration complete; no grant while low.
REQ-005 wr_req  in  1  level write-burst request, held until wr_finish; wr_addr  in  ADDR_W  burst start address; wr_length  in  LEN_W  beats.
REQ-006 wr_ack  out  1  write-FIFO pop strobe, one per beat accepted; wr_data  in  DATA_W  show-ahead FIFO head; wr_finish  out  1  one-cycle done pulse.
REQ-007 rd_req  in  1  level read-burst request; rd_addr  in  ADDR_W; rd_length  in  LEN_W; rd_ack  out  1  read-FIFO push strobe; rd_data  out  DATA_W; rd_finish  out  1  one-cycle done pulse.
REQ-008 app_en  out  1  command valid; app_cmd  out  3  0=write, 1=read; app_addr  out  ADDR_W; app_rdy  in  1  command accepted when high with app_en.
REQ-009 app_wdf_wren  out  1  write-data valid; app_wdf_data  out  DATA_W; app_wdf_rdy  in  1  data accepted when high with app_wdf_wren.
REQ-010 app_rd_data_valid  in  1; app_rd_data  in  DATA_W  returned read beat.

Function
REQ-011 FSM states SHALL be IDLE, WRITE, READ, DONE.
REQ-012 IDLE: if init_done=0, remain IDLE; else if exactly one request high, grant it at the next edge; if both high, grant the side not granted last (round-robin); last_grant resets to READ so write wins the first tie.
REQ-013 On grant, wr_addr/rd_addr and length SHALL be latched; later changes on those inputs are ignored until DONE.
REQ-014 WRITE: cmd counter and data counter run independently from 0; app_en=1,app_cmd=0 while cmd_cnt<len; app_addr=base+cmd_cnt*ADDR_STEP (mod 2^ADDR_W).
REQ-015 WRITE: app_wdf_wren=1 while data_cnt<len; app_wdf_data=wr_data combinationally; wr_ack=app_wdf_wren&app_wdf_rdy; data_cnt increments on that condition.
REQ-016 cmd_cnt SHALL increment only on app_en&app_rdy; stalls hold app_addr stable.
REQ-017 WRITE -> DONE when cmd_cnt==len and data_cnt==len (both counters LEN_W+1 bits, no overflow at len=1023).
REQ-018 READ: app_en=1,app_cmd=1 while cmd_cnt<len, same address rule; rd_ack=app_rd_data_valid, rd_data=app_rd_data; ret_cnt increments per valid beat; READ -> DONE when cmd_cnt==len and ret_cnt==len.
REQ-019 app_rd_data_valid outside READ SHALL be ignored (no rd_ack).
REQ-020 DONE lasts exactly one cycle, asserting wr_finish or rd_finish for the granted side, then IDLE; no grant is issued in the DONE cycle.
REQ-021 Length 0: state enters WRITE/READ, issues no command/data, transitions to DONE next cycle.
REQ-022 init_done falling mid-burst SHALL NOT abort; the burst completes.
REQ-023 Grant latency: request sampled in IDLE -> first app_en in the following cycle.

Reset
REQ-024 rst SHALL asynchronously force IDLE, counters 0, last_grant=READ, and app_en, app_wdf_wren, wr_ack, rd_ack, wr_finish, rd_finish to 0 (app_cmd/app_addr 0).
REQ-025 rst mid-burst SHALL abandon the burst with no finish pulse; after release, requests are re-arbitrated from IDLE.

Verification
REQ-026 init_done=1, wr_req, wr_addr=0x100, wr_length=4, rdy always 1 -> app_addr 0x100..0x103, 4 wr_ack, wr_finish one cycle after last beat.
REQ-027 wr_req and rd_req high together from reset -> write granted first, then read; next tie -> write again only after read.
REQ-028 Read length 3, app_rdy toggling 1/0, data returning 5 cycles late -> 3 commands, addresses hold during stall, 3 rd_ack, rd_finish after third beat.
REQ-029 init_done=0 with both requests high 20 cycles -> no app_en; grant within 1 cycle of init_done rising.
REQ-030 wr_length=0 -> no app_en/wren, wr_finish 2 cycles after grant; rst pulse mid length-8 write -> outputs 0 immediately, no wr_finish.
